memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory_pkg.sv | 12 +
 rtl/memory.sv | 95 +++++++++
 tb/tb_memory.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the word memory and the processor that uses it.
package memory_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 6;
    localparam int unsigned MEM_DATA_WIDTH = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

endpackage : memory_pkg

// File: rtl/memory.sv
// Single-port word memory with a loader write port and an optional zero-fill
// sweep after reset. Reads are registered and read-first.
module memory
    import memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = MEM_DATA_WIDTH,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] out,
    input  logic                  boot_we,
    input  logic [ADDR_WIDTH-1:0] boot_addr,
    input  logic [DATA_WIDTH-1:0] boot_data,
    output logic                  busy
);

    localparam int unsigned DEPTH       = 32'(1) << ADDR_WIDTH;
    localparam mem_state_e  RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    mem_state_e            state_q;
    logic [ADDR_WIDTH-1:0] sweep_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  busy_q;

    logic                  wr_en_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic [DATA_WIDTH-1:0] wr_data_c;

    // Array write port: sweep in CLEAR, loader over processor in READY.
    // Note rst_n is active-high: no array write while it is asserted.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = addr;
        wr_data_c = data;
        if (!rst_n) begin
            if (state_q == ST_CLEAR) begin
                wr_en_c   = 1'b1;
                wr_addr_c = sweep_q;
                wr_data_c = '0;
            end else if (boot_we) begin
                wr_en_c   = 1'b1;
                wr_addr_c = boot_addr;
                wr_data_c = boot_data;
            end else if (we) begin
                wr_en_c   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_addr_c] <= wr_data_c;
        end
    end

    // Control FSM: sweep counter, busy flag and registered read data.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= RESET_STATE;
            busy_q  <= CLEAR_ON_RESET;
            sweep_q <= '0;
            out_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    out_q   <= '0;
                    sweep_q <= sweep_q + ADDR_WIDTH'(1);
                    if (&sweep_q) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                ST_READY: begin
                    out_q <= mem_q[addr];
                end
                default: begin
                    state_q <= RESET_STATE;
                    busy_q  <= CLEAR_ON_RESET;
                    sweep_q <= '0;
                    out_q   <= '0;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule : memory

// File: tb/tb_memory.sv
// Scoreboard bench for memory: driver pushes expected out/busy from an array
// model, an independent monitor pops and compares after every rising edge.
module tb_memory;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] out;
    logic          boot_we = 1'b0;
    logic [AW-1:0] boot_addr = '0;
    logic [DW-1:0] boot_data = '0;
    logic          busy;

    memory dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .addr      (addr),
        .data      (data),
        .out       (out),
        .boot_we   (boot_we),
        .boot_addr (boot_addr),
        .boot_data (boot_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] out;
        logic          busy;
        int            phase;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            phase = 0;

    // Reference model: plain array plus count of sweep cycles still to run.
    logic [DW-1:0] m [DEPTH];
    int            clear_left = 0;

    task automatic cyc(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic bw,
                       input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        exp_t e;
        @(negedge clk);
        rst_n = r; we = w; addr = a; data = d;
        boot_we = bw; boot_addr = ba; boot_data = bd;
        if (r) begin
            clear_left = DEPTH;
            e.out = '0;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                foreach (m[i]) m[i] = '0;
            end
            e.out = '0;
        end else begin
            e.out = m[a];
            if (bw)     m[ba] = bd;
            else if (w) m[a]  = d;
        end
        e.busy  = (clear_left > 0);
        e.phase = phase;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(1'b0, 1'b0, a, '0, 1'b0, '0, '0);
    endtask

    task automatic noisy(input logic r);
        cyc(r, 1'($urandom), AW'($urandom), DW'($urandom),
            1'($urandom), AW'($urandom), DW'($urandom));
    endtask

    task automatic rand_cycle();
        logic bw;
        bw = ($urandom_range(3) == 0);
        cyc(1'b0, 1'($urandom), AW'($urandom_range(15)), DW'($urandom),
            bw, AW'($urandom_range(15)), DW'($urandom));
    endtask

    // Monitor: one expected item per clock edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (out !== e.out || busy !== e.busy) begin
                    n_err++;
                    $display("FAIL phase%0d t=%0t: got out=%h busy=%b, want out=%h busy=%b",
                             e.phase, $time, out, busy, e.out, e.busy);
                end
            end
        end
    end

    initial begin
        // Reset, full sweep, then every word reads zero.
        phase = 1;
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 64; i++) idle();
        phase = 2;
        for (int i = 0; i < 64; i++) rd(AW'(i));
        idle();

        // Write then read back.
        phase = 3;
        cyc(1'b0, 1'b1, 6'd5, 16'hBEEF, 1'b0, '0, '0);
        rd(6'd5);
        idle();

        // Read-first on a same-cycle write.
        phase = 4;
        cyc(1'b0, 1'b1, 6'd9, 16'h1111, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 6'd9, 16'h2222, 1'b0, '0, '0);
        rd(6'd9);
        idle();

        // Loader priority over processor write to the same word.
        phase = 5;
        cyc(1'b0, 1'b1, 6'd3, 16'h5555, 1'b1, 6'd3, 16'h00AA);
        rd(6'd3);
        idle();

        // Loader write to a different word drops the processor write there.
        phase = 6;
        cyc(1'b0, 1'b1, 6'd12, 16'h1234, 1'b1, 6'd13, 16'h4321);
        rd(6'd12);
        rd(6'd13);
        idle();

        // Processor read of the word the loader writes returns the old value.
        phase = 7;
        cyc(1'b0, 1'b0, 6'd5, '0, 1'b1, 6'd5, 16'h7777);
        rd(6'd5);
        idle();

        phase = 8;
        for (int i = 0; i < 400; i++) rand_cycle();

        // Reset mid-sweep with bus noise; sweep restarts and all words clear.
        phase = 9;
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 6'd0, 16'hFFFF, 1'b1, 6'd0, 16'hFFFF);
        for (int i = 1; i < 20; i++) noisy(1'b0);
        cyc(1'b1, 1'b1, 6'd0, 16'hFFFF, 1'b1, 6'd1, 16'hFFFF);
        for (int i = 0; i < 64; i++) noisy(1'b0);
        phase = 10;
        for (int i = 0; i < 64; i++) rd(AW'(i));

        phase = 11;
        for (int i = 0; i < 200; i++) rand_cycle();
        for (int i = 0; i < 64; i++) rd(AW'(i));
        idle();

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected items left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_memory
